// File: rtl/dbg_pkg.sv
// Shared command/state types, coprocessor control bit positions and halt causes
// for the host-side debug controller.
package dbg_pkg;

  typedef enum logic [2:0] {
    OP_HALT   = 3'd0,
    OP_RESUME = 3'd1,
    OP_STEP   = 3'd2,
    OP_RD_REG = 3'd3,
    OP_WR_REG = 3'd4,
    OP_RD_CSR = 3'd5,
    OP_WR_CSR = 3'd6
  } dbg_op_t;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_HALTED  = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_STEP    = 3'd4,
    ST_RESP    = 3'd5
  } dbg_state_t;

  localparam int CTRL_WE   = 0;
  localparam int CTRL_RD   = 1;
  localparam int CTRL_HALT = 2;
  localparam int CTRL_CSR  = 3;

  localparam int REG_ADDR_W = 5;
  localparam int CSR_ADDR_W = 12;

  localparam logic [1:0] HALT_CAUSE_HOST  = 2'd0;
  localparam logic [1:0] HALT_CAUSE_FETCH = 2'd1;
  localparam logic [1:0] HALT_CAUSE_EXEC  = 2'd2;
  localparam logic [1:0] HALT_CAUSE_STEP  = 2'd3;

  // An execute-stage break outranks a fetch break when both are flagged.
  function automatic logic [1:0] break_cause(input logic [1:0] brk);
    return brk[1] ? HALT_CAUSE_EXEC : HALT_CAUSE_FETCH;
  endfunction

  function automatic logic op_is_access(input dbg_op_t op);
    case (op)
      OP_RD_REG, OP_WR_REG, OP_RD_CSR, OP_WR_CSR: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_read(input dbg_op_t op);
    case (op)
      OP_RD_REG, OP_RD_CSR: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_csr(input dbg_op_t op);
    case (op)
      OP_RD_CSR, OP_WR_CSR: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/debug_controller.sv
// Host debug sequencer: halts/resumes/steps the core and sequences register-file
// and CSR accesses over the datapath coprocessor IO port. All port outputs are registered.
module debug_controller
  import dbg_pkg::*;
#(
  parameter int N      = 64,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [N-1:0]      cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_err,
  input  logic [1:0]        breakSrc,
  output logic [ADDR_W-1:0] coprocessorIOAddr,
  output logic [4:0]        coprocessorIOControl,
  output logic [N-1:0]      coprocessorIODataOut,
  input  logic [N-1:0]      coprocessorIODataIn,
  output logic              halted,
  output logic [1:0]        halt_cause
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [N-1:0]      DATA_ZERO = {N{1'b0}};

  dbg_state_t        state_r, state_s;
  logic [4:0]        ctrl_r, ctrl_s, acc_ctrl_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [N-1:0]      dout_r, dout_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [N-1:0]      rsp_data_r, rsp_data_s;
  logic              rsp_err_r, rsp_err_s;
  logic              halted_r, halted_s;
  logic [1:0]        cause_r, cause_s;

  dbg_op_t           op_s;
  logic              accept_s, rsp_done_s, addr_bad_s;
  logic              new_rsp_s, new_err_s;
  logic [N-1:0]      new_data_s;

  assign op_s       = dbg_op_t'(cmd_op);
  assign cmd_ready  = ((state_r == ST_RUN) || (state_r == ST_HALTED)) && !rsp_valid_r;
  assign accept_s   = cmd_valid && cmd_ready;
  assign rsp_done_s = rsp_valid_r && rsp_ready;

  // Address range check and coprocessor control word for an access command.
  always_comb begin
    addr_bad_s = 1'b0;
    if (op_is_csr(op_s)) begin
      addr_bad_s = (cmd_addr >> CSR_ADDR_W) != ADDR_ZERO;
    end else begin
      addr_bad_s = (cmd_addr >> REG_ADDR_W) != ADDR_ZERO;
    end
    acc_ctrl_s            = 5'b0_0000;
    acc_ctrl_s[CTRL_HALT] = 1'b1;
    acc_ctrl_s[CTRL_CSR]  = op_is_csr(op_s);
    acc_ctrl_s[CTRL_RD]   = op_is_read(op_s);
    acc_ctrl_s[CTRL_WE]   = op_is_access(op_s) && !op_is_read(op_s);
  end

  // Next state, halt cause and host response selection.
  always_comb begin
    state_s     = state_r;
    cause_s     = cause_r;
    new_rsp_s   = 1'b0;
    new_err_s   = 1'b0;
    new_data_s  = DATA_ZERO;
    rsp_valid_s = rsp_valid_r;
    rsp_data_s  = rsp_data_r;
    rsp_err_s   = rsp_err_r;

    case (state_r)
      ST_RUN: begin
        if (breakSrc != 2'b00) begin
          state_s = ST_HALTED;
          cause_s = break_cause(breakSrc);
        end else begin
          state_s = ST_RUN;
        end
        if (accept_s) begin
          new_rsp_s = 1'b1;
          if (op_s == OP_HALT) begin
            state_s = ST_HALTED;
            cause_s = (breakSrc != 2'b00) ? break_cause(breakSrc) : HALT_CAUSE_HOST;
          end else begin
            new_err_s = 1'b1;
          end
        end else begin
          new_rsp_s = 1'b0;
        end
      end
      ST_HALTED: begin
        if (accept_s) begin
          new_rsp_s = 1'b1;
          case (op_s)
            OP_HALT:   state_s = ST_HALTED;
            OP_RESUME: state_s = ST_RUN;
            OP_STEP:   state_s = ST_STEP;
            OP_RD_REG, OP_WR_REG, OP_RD_CSR, OP_WR_CSR: begin
              if (addr_bad_s) begin
                new_err_s = 1'b1;
                state_s   = ST_HALTED;
              end else begin
                new_rsp_s = 1'b0;
                state_s   = ST_ACCESS;
              end
            end
            default: begin
              new_err_s = 1'b1;
              state_s   = ST_HALTED;
            end
          endcase
        end else begin
          state_s = ST_HALTED;
        end
      end
      ST_ACCESS: begin
        if (ctrl_r[CTRL_RD]) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s   = ST_RESP;
          new_rsp_s = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_s    = ST_RESP;
        new_rsp_s  = 1'b1;
        new_data_s = coprocessorIODataIn;
      end
      ST_STEP: begin
        state_s = ST_HALTED;
        if (breakSrc != 2'b00) begin
          cause_s = break_cause(breakSrc);
        end else begin
          cause_s = HALT_CAUSE_STEP;
        end
      end
      ST_RESP: begin
        if (rsp_done_s) begin
          state_s = ST_HALTED;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_RUN;
    endcase

    // A new response can only be raised while none is pending, so it never races a handshake.
    if (new_rsp_s) begin
      rsp_valid_s = 1'b1;
      rsp_err_s   = new_err_s;
      rsp_data_s  = new_data_s;
    end else if (rsp_done_s) begin
      rsp_valid_s = 1'b0;
      rsp_err_s   = 1'b0;
      rsp_data_s  = DATA_ZERO;
    end else begin
      rsp_valid_s = rsp_valid_r;
      rsp_err_s   = rsp_err_r;
      rsp_data_s  = rsp_data_r;
    end
  end

  // Datapath port values follow the state being entered, so they are glitch-free registers.
  always_comb begin
    ctrl_s   = 5'b0_0000;
    addr_s   = ADDR_ZERO;
    dout_s   = DATA_ZERO;
    halted_s = 1'b1;
    case (state_s)
      ST_RUN, ST_STEP: begin
        halted_s = 1'b0;
      end
      ST_HALTED, ST_RESP: begin
        ctrl_s[CTRL_HALT] = 1'b1;
      end
      ST_CAPTURE: begin
        ctrl_s[CTRL_HALT] = 1'b1;
        addr_s            = addr_r;
      end
      ST_ACCESS: begin
        ctrl_s = acc_ctrl_s;
        addr_s = cmd_addr;
        if (acc_ctrl_s[CTRL_WE]) begin
          dout_s = cmd_data;
        end else begin
          dout_s = DATA_ZERO;
        end
      end
      default: begin
        halted_s = 1'b0;
      end
    endcase
  end

  // State and output register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_RUN;
      ctrl_r      <= 5'b0_0000;
      addr_r      <= ADDR_ZERO;
      dout_r      <= DATA_ZERO;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= DATA_ZERO;
      rsp_err_r   <= 1'b0;
      halted_r    <= 1'b0;
      cause_r     <= HALT_CAUSE_HOST;
    end else begin
      state_r     <= state_s;
      ctrl_r      <= ctrl_s;
      addr_r      <= addr_s;
      dout_r      <= dout_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
      halted_r    <= halted_s;
      cause_r     <= cause_s;
    end
  end

  assign coprocessorIOControl = ctrl_r;
  assign coprocessorIOAddr    = addr_r;
  assign coprocessorIODataOut = dout_r;
  assign rsp_valid            = rsp_valid_r;
  assign rsp_data             = rsp_data_r;
  assign rsp_err              = rsp_err_r;
  assign halted               = halted_r;
  assign halt_cause           = cause_r;

endmodule

// File: tb/tb_debug_controller.sv
// Scoreboard bench for debug_controller with a small datapath stub (PC, register file, CSRs).
module tb_debug_controller;
  import dbg_pkg::*;

  localparam int N  = 64;
  localparam int AW = 15;

  typedef struct {
    logic [N-1:0] data;
    logic         err;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [N-1:0]  cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          rsp_err;
  logic [1:0]    break_src;
  logic [AW-1:0] io_addr;
  logic [4:0]    io_ctrl;
  logic [N-1:0]  io_dout;
  logic [N-1:0]  io_din;
  logic          halted;
  logic [1:0]    halt_cause;

  logic [N-1:0]  pc;
  logic [N-1:0]  rf [32];
  logic [N-1:0]  csr_mem [4096];

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_tests = 0;
  int            n_fail = 0;
  int            halt_drops = 0;
  logic          watch_halt = 1'b0;
  logic [N-1:0]  p1, pc_h;

  debug_controller #(.N(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .breakSrc(break_src),
    .coprocessorIOAddr(io_addr), .coprocessorIOControl(io_ctrl),
    .coprocessorIODataOut(io_dout), .coprocessorIODataIn(io_din),
    .halted(halted), .halt_cause(halt_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Datapath stub: PC runs only with a zero control word; reads return one cycle after the strobe.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= 64'd0;
      io_din <= 64'd0;
    end else begin
      if (io_ctrl == 5'd0) pc <= pc + 64'd4;
      if (io_ctrl[0]) begin
        if (io_ctrl[3]) csr_mem[io_addr[11:0]] <= io_dout;
        else if (io_addr[4:0] != 5'd0) rf[io_addr[4:0]] <= io_dout;
      end
      if (io_ctrl[1]) begin
        if (io_ctrl[3]) io_din <= csr_mem[io_addr[11:0]];
        else if (io_addr[4:0] == 5'd0) io_din <= 64'd0;
        else io_din <= rf[io_addr[4:0]];
      end
    end
  end

  // Response scoreboard and halt-drop monitor.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("rsp_data", rsp_data, mon_e.data);
        check_eq("rsp_err", {63'd0, rsp_err}, {63'd0, mon_e.err});
      end
    end
    if (watch_halt && !io_ctrl[2]) halt_drops++;
  end

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [N-1:0] d,
                       input logic [1:0] brk, input logic [N-1:0] exp_data, input logic exp_err);
    int waited;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; break_src = brk;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check_eq("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
    e.data = exp_data;
    e.err  = exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = '0; cmd_data = '0; break_src = 2'b00;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ctrl"}, {59'd0, io_ctrl}, 64'd0);
    check_eq({pfx, "_addr"}, {49'd0, io_addr}, 64'd0);
    check_eq({pfx, "_dout"}, io_dout, 64'd0);
    check_eq({pfx, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check_eq({pfx, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
    check_eq({pfx, "_rsp_data"}, rsp_data, 64'd0);
    check_eq({pfx, "_halted"}, {63'd0, halted}, 64'd0);
    check_eq({pfx, "_cause"}, {62'd0, halt_cause}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1; break_src = 2'b00;
    #2 reset = 1'b0;
    #2 check_reset_outputs("rst");
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Commands other than HALT are rejected while running; PC keeps moving.
    issue(OP_RD_REG, 15'd5, 64'd0, 2'b00, 64'd0, 1'b1);
    @(negedge clk);
    check_eq("run_rd_ctrl", {59'd0, io_ctrl}, 64'd0);
    p1 = pc;
    repeat (3) @(negedge clk);
    check_eq("run_pc_adv", pc, p1 + 64'd12);

    // Halt, then register/CSR accesses with cycle-exact latency.
    issue(OP_HALT, 15'd0, 64'd0, 2'b00, 64'd0, 1'b0);
    @(negedge clk);
    check_eq("halt_halted", {63'd0, halted}, 64'd1);
    check_eq("halt_cause", {62'd0, halt_cause}, 64'd0);
    check_eq("halt_ctrl", {59'd0, io_ctrl}, 64'h04);
    pc_h = pc;
    watch_halt = 1'b1;

    issue(OP_WR_REG, 15'd7, 64'hDEAD_BEEF, 2'b00, 64'd0, 1'b0);
    @(negedge clk);
    check_eq("wr_ctrl", {59'd0, io_ctrl}, 64'h05);
    check_eq("wr_addr", {49'd0, io_addr}, 64'd7);
    check_eq("wr_dout", io_dout, 64'hDEAD_BEEF);
    check_eq("wr_rsp_c1", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    check_eq("wr_rsp_c2", {63'd0, rsp_valid}, 64'd1);
    check_eq("wr_ctrl_c2", {59'd0, io_ctrl}, 64'h04);
    check_eq("wr_dout_c2", io_dout, 64'd0);

    issue(OP_RD_REG, 15'd7, 64'd0, 2'b00, 64'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check_eq("rd_ctrl", {59'd0, io_ctrl}, 64'h06);
    check_eq("rd_rsp_c1", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    check_eq("rd_rsp_c2", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    check_eq("rd_rsp_c3", {63'd0, rsp_valid}, 64'd1);
    check_eq("rd_data_c3", rsp_data, 64'hDEAD_BEEF);

    issue(OP_WR_REG, 15'd9, 64'h1111, 2'b00, 64'd0, 1'b0);
    issue(OP_WR_REG, 15'd0, 64'h55, 2'b00, 64'd0, 1'b0);
    issue(OP_RD_REG, 15'd0, 64'd0, 2'b00, 64'd0, 1'b0);
    issue(OP_RD_REG, 15'h0020, 64'd0, 2'b00, 64'd0, 1'b1);
    @(negedge clk);
    check_eq("badreg_ctrl", {59'd0, io_ctrl}, 64'h04);
    issue(OP_WR_CSR, 15'h0300, 64'hCAFE_F00D_1234_5678, 2'b00, 64'd0, 1'b0);
    @(negedge clk);
    check_eq("wrcsr_ctrl", {59'd0, io_ctrl}, 64'h0D);
    issue(OP_RD_CSR, 15'h0300, 64'd0, 2'b00, 64'hCAFE_F00D_1234_5678, 1'b0);
    @(negedge clk);
    check_eq("rdcsr_ctrl", {59'd0, io_ctrl}, 64'h0E);
    repeat (3) @(negedge clk);
    watch_halt = 1'b0;
    check_eq("halt_drops", 64'(halt_drops), 64'd0);
    check_eq("halt_pc_frozen", pc, pc_h);

    // Single step retires exactly one instruction.
    pc_h = pc;
    issue(OP_STEP, 15'd0, 64'd0, 2'b00, 64'd0, 1'b0);
    @(negedge clk);
    check_eq("step_ctrl", {59'd0, io_ctrl}, 64'd0);
    check_eq("step_halted", {63'd0, halted}, 64'd0);
    @(negedge clk);
    check_eq("step_pc", pc, pc_h + 64'd4);
    check_eq("step_ctrl2", {59'd0, io_ctrl}, 64'h04);
    check_eq("step_halted2", {63'd0, halted}, 64'd1);
    check_eq("step_cause", {62'd0, halt_cause}, 64'd3);
    repeat (2) @(negedge clk);
    check_eq("step_pc_hold", pc, pc_h + 64'd4);

    issue(OP_STEP, 15'd0, 64'd0, 2'b00, 64'd0, 1'b0);
    break_src = 2'b01;
    @(posedge clk); #1 break_src = 2'b00;
    @(negedge clk);
    check_eq("stepbrk_cause", {62'd0, halt_cause}, 64'd1);
    check_eq("stepbrk_halted", {63'd0, halted}, 64'd1);

    // Break while running, alone and together with a host HALT.
    issue(OP_RESUME, 15'd0, 64'd0, 2'b00, 64'd0, 1'b0);
    @(negedge clk);
    check_eq("resume_ctrl", {59'd0, io_ctrl}, 64'd0);
    check_eq("resume_halted", {63'd0, halted}, 64'd0);
    @(posedge clk); #1 break_src = 2'b10;
    @(posedge clk); #1 break_src = 2'b00;
    @(negedge clk);
    check_eq("brk_halted", {63'd0, halted}, 64'd1);
    check_eq("brk_cause", {62'd0, halt_cause}, 64'd2);
    check_eq("brk_ctrl", {59'd0, io_ctrl}, 64'h04);
    issue(OP_RESUME, 15'd0, 64'd0, 2'b00, 64'd0, 1'b0);
    issue(OP_HALT, 15'd0, 64'd0, 2'b10, 64'd0, 1'b0);
    @(negedge clk);
    check_eq("brkhalt_cause", {62'd0, halt_cause}, 64'd2);
    check_eq("brkhalt_halted", {63'd0, halted}, 64'd1);

    // Out-of-range CSR address with the host back-pressuring the response.
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(OP_RD_CSR, 15'h1300, 64'd0, 2'b00, 64'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check_eq("bp_rsp_err", {63'd0, rsp_err}, 64'd1);
      check_eq("bp_rsp_data", rsp_data, 64'd0);
      check_eq("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check_eq("bp_ctrl", {59'd0, io_ctrl}, 64'h04);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;

    // Reset in the middle of a write aborts it and drops the response.
    issue(OP_WR_REG, 15'd9, 64'h2222, 2'b00, 64'd0, 1'b0);
    #2;
    check_eq("abort_pre_ctrl", {59'd0, io_ctrl}, 64'h05);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("midrst_run_ctrl", {59'd0, io_ctrl}, 64'd0);
    issue(OP_HALT, 15'd0, 64'd0, 2'b00, 64'd0, 1'b0);
    issue(OP_RD_REG, 15'd9, 64'd0, 2'b00, 64'h1111, 1'b0);

    repeat (6) @(negedge clk);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
